// File: rtl/jno_sequencer.sv
// Instruction sequencer: fetches over req/ack, issues opcode/operand, resolves JNO against the ALU zero flag.
// Optional macro PAPER_SEQ_BRANCH_COUNT_EN adds a saturating 16-bit taken-jump counter output.
module jno_sequencer #(
    parameter int PC_WIDTH    = 4,
    parameter int INSTR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [PC_WIDTH-1:0]    imem_addr,
    output logic                   imem_req,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    input  logic                   zero_flag,
    input  logic                   stall,
    output logic [1:0]             instruct,
    output logic                   enabled,
    output logic [INSTR_WIDTH-3:0] operand,
    output logic                   instr_valid,
`ifdef PAPER_SEQ_BRANCH_COUNT_EN
    output logic                   halted,
    output logic [15:0]            branch_count
`else
    output logic                   halted
`endif
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t                 state_r, next_state_s;
    logic [PC_WIDTH-1:0]    pc_r, pc_next_s, target_s;
    logic [INSTR_WIDTH-1:0] ir_r;
    logic                   ir_load_s, taken_s, enabled_s;
    logic                   imem_req_r, instr_valid_r, halted_r;

    assign target_s = ir_r[PC_WIDTH-1:0];

    // Next-state, next-pc and the combinational jump decision
    always_comb begin
        next_state_s = state_r;
        pc_next_s    = pc_r;
        ir_load_s    = 1'b0;
        taken_s      = 1'b0;
        enabled_s    = 1'b0;
        case (state_r)
            FETCH: begin
                // an ack is only honoured while our request is actually out
                if (imem_req_r && imem_ack) begin
                    ir_load_s    = 1'b1;
                    next_state_s = ISSUE;
                end else begin
                    next_state_s = FETCH;
                end
            end
            ISSUE: begin
                enabled_s = (ir_r[INSTR_WIDTH-1:INSTR_WIDTH-2] == 2'b11) && !zero_flag;
                if (stall) begin
                    next_state_s = ISSUE;
                end else if (enabled_s) begin
                    taken_s      = 1'b1;
                    pc_next_s    = target_s;
                    next_state_s = (target_s == pc_r) ? HALT : FETCH;
                end else begin
                    pc_next_s    = pc_r + {{(PC_WIDTH-1){1'b0}}, 1'b1};
                    next_state_s = FETCH;
                end
            end
            HALT: begin
                next_state_s = HALT;
            end
            default: begin
                next_state_s = FETCH;
            end
        endcase
    end

    // State, pc, instruction register and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= FETCH;
            pc_r          <= {PC_WIDTH{1'b0}};
            ir_r          <= {INSTR_WIDTH{1'b0}};
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b0;
            halted_r      <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            pc_r          <= pc_next_s;
            if (ir_load_s) begin
                ir_r <= imem_data;
            end
            imem_req_r    <= (next_state_s == FETCH);
            instr_valid_r <= (next_state_s == ISSUE);
            halted_r      <= (next_state_s == HALT);
        end
    end

`ifdef PAPER_SEQ_BRANCH_COUNT_EN
    logic [15:0] branch_count_r;

    // Saturating count of taken jumps, self-jumps included
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_count_r <= 16'h0000;
        end else if (taken_s && (branch_count_r != 16'hFFFF)) begin
            branch_count_r <= branch_count_r + 16'h0001;
        end
    end

    assign branch_count = branch_count_r;
`endif

    assign imem_addr   = pc_r;
    assign imem_req    = imem_req_r;
    assign instr_valid = instr_valid_r;
    assign halted      = halted_r;
    assign instruct    = ir_r[INSTR_WIDTH-1:INSTR_WIDTH-2];
    assign operand     = ir_r[INSTR_WIDTH-3:0];
    // enabled follows zero_flag live while an instruction is held in issue
    assign enabled     = enabled_s;

endmodule

// File: tb/tb_jno_sequencer.sv
// Scoreboard bench for jno_sequencer: directed program, memory responder, issue monitor.
module tb_jno_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] imem_addr;
    logic       imem_req;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic       zero_flag;
    logic       stall;
    logic [1:0] instruct;
    logic       enabled;
    logic [5:0] operand;
    logic       instr_valid;
    logic       halted;
`ifdef PAPER_SEQ_BRANCH_COUNT_EN
    logic [15:0] branch_count;
`endif

    typedef struct {
        logic [1:0] ins;
        logic [5:0] op;
        logic       en;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] exp_addr_q[$];
    logic [7:0] mem [16];
    int         checks = 0;
    int         errors = 0;
    int         ack_dly = 0;
    logic       mem_en = 1'b0;

    jno_sequencer dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_ack(imem_ack), .imem_data(imem_data), .zero_flag(zero_flag), .stall(stall),
        .instruct(instruct), .enabled(enabled), .operand(operand), .instr_valid(instr_valid),
`ifdef PAPER_SEQ_BRANCH_COUNT_EN
        .halted(halted), .branch_count(branch_count)
`else
        .halted(halted)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: acks after ack_dly waiting cycles and checks the fetch address
    always @(posedge clk) begin : memory
        static int cnt = 0;
        static logic [3:0] addr0 = 4'h0;
        #2;
        if (reset || !mem_en) begin
            imem_ack = 1'b0;
            cnt = 0;
        end else if (imem_req && !imem_ack) begin
            if (cnt == 0) addr0 = imem_addr;
            else begin
                check("addr_stable", {28'h0, imem_addr}, {28'h0, addr0});
            end
            if (cnt >= ack_dly) begin
                imem_ack  = 1'b1;
                imem_data = mem[imem_addr];
                cnt = 0;
                if (exp_addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL fetch_addr: unexpected fetch at %0h", imem_addr);
                end else begin
                    check("fetch_addr", {28'h0, imem_addr}, {28'h0, exp_addr_q.pop_front()});
                end
            end else begin
                imem_ack = 1'b0;
                cnt++;
            end
        end else begin
            imem_ack = 1'b0;
            cnt = 0;
        end
    end

    // Monitor: pops the scoreboard on each accepted issue cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (enabled && !instr_valid) begin
                errors++;
                $display("FAIL en_wo_valid: enabled=1 with instr_valid=0");
            end
            if (instr_valid && !stall) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL issue: unexpected issue instruct=%0h operand=%0h", instruct, operand);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checks++;
                    if (instruct !== e.ins || operand !== e.op || enabled !== e.en) begin
                        errors++;
                        $display("FAIL issue: got ins=%0h op=%0h en=%0b expected ins=%0h op=%0h en=%0b",
                                 instruct, operand, enabled, e.ins, e.op, e.en);
                    end
                end
            end
        end
    end

    task automatic run_step(input logic [3:0] addr, input logic zf, input int dly,
                            input logic [1:0] ins, input logic [5:0] op, input logic en,
                            input int nstall, input int exp_wait, input logic halt);
        int n = 0;
        exp_addr_q.push_back(addr);
        exp_q.push_back('{ins, op, en});
        ack_dly   = dly;
        zero_flag = zf;
        while (!instr_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!instr_valid) begin
            errors++;
            $display("FAIL timeout: no issue for addr %0h", addr);
            return;
        end
        check("issue_latency", n, exp_wait);
        if (nstall > 0) begin
            stall = 1'b1;
            for (int k = 0; k < nstall; k++) begin
                zero_flag = (k % 2 == 1);
                @(negedge clk);
                check("stall_ins", {30'h0, instruct}, {30'h0, ins});
                check("stall_op", {26'h0, operand}, {26'h0, op});
                check("stall_en", {31'h0, enabled}, {31'h0, (ins == 2'b11) && !zero_flag});
                check("stall_pc", {28'h0, imem_addr}, {28'h0, addr});
                @(posedge clk); #1;
            end
            stall     = 1'b0;
            zero_flag = zf;
        end
        @(posedge clk); #1;
        check("post_req", {31'h0, imem_req}, {31'h0, !halt});
        check("post_halted", {31'h0, halted}, {31'h0, halt});
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0] = 8'h41; mem[1] = 8'h82; mem[2] = 8'h05; mem[3] = 8'hC9;
        mem[4] = 8'hCA; mem[5] = 8'hC5; mem[9] = 8'hC3; mem[10] = 8'hCF; mem[15] = 8'h81;
        reset = 1'b1; stall = 1'b0; zero_flag = 1'b0; imem_ack = 1'b0; imem_data = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_addr", {28'h0, imem_addr}, 32'h0);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_ins", {30'h0, instruct}, 32'h0);
        check("rst_op", {26'h0, operand}, 32'h0);
        check("rst_halted", {31'h0, halted}, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("first_req", {31'h0, imem_req}, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midfetch_req", {31'h0, imem_req}, 32'h0);
        check("midfetch_valid", {31'h0, instr_valid}, 32'h0);
        check("midfetch_en", {31'h0, enabled}, 32'h0);
        check("midfetch_halted", {31'h0, halted}, 32'h0);
        check("midfetch_addr", {28'h0, imem_addr}, 32'h0);
        @(posedge clk); #1;
        reset  = 1'b0;
        mem_en = 1'b1;

        //        addr  zf    dly ins    op     en    stall wait halt
        run_step(4'h0, 1'b1, 0, 2'b01, 6'h01, 1'b0, 0, 2, 1'b0);
        run_step(4'h1, 1'b1, 0, 2'b10, 6'h02, 1'b0, 0, 1, 1'b0);
        run_step(4'h2, 1'b1, 1, 2'b00, 6'h05, 1'b0, 0, 2, 1'b0);
        run_step(4'h3, 1'b0, 0, 2'b11, 6'h09, 1'b1, 0, 1, 1'b0);
`ifdef PAPER_SEQ_BRANCH_COUNT_EN
        check("bc_one", {16'h0, branch_count}, 32'h1);
`endif
        run_step(4'h9, 1'b0, 0, 2'b11, 6'h03, 1'b1, 0, 1, 1'b0);
        run_step(4'h3, 1'b1, 0, 2'b11, 6'h09, 1'b0, 0, 1, 1'b0);
        run_step(4'h4, 1'b0, 3, 2'b11, 6'h0A, 1'b1, 4, 4, 1'b0);
        run_step(4'hA, 1'b0, 0, 2'b11, 6'h0F, 1'b1, 0, 1, 1'b0);
        run_step(4'hF, 1'b0, 2, 2'b10, 6'h01, 1'b0, 0, 3, 1'b0);
        run_step(4'h0, 1'b1, 0, 2'b01, 6'h01, 1'b0, 0, 1, 1'b0);
        run_step(4'h1, 1'b1, 0, 2'b10, 6'h02, 1'b0, 0, 1, 1'b0);
        run_step(4'h2, 1'b1, 0, 2'b00, 6'h05, 1'b0, 0, 1, 1'b0);
        run_step(4'h3, 1'b1, 0, 2'b11, 6'h09, 1'b0, 0, 1, 1'b0);
        run_step(4'h4, 1'b1, 0, 2'b11, 6'h0A, 1'b0, 0, 1, 1'b0);
        run_step(4'h5, 1'b0, 0, 2'b11, 6'h05, 1'b1, 0, 1, 1'b1);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("halt_req", {31'h0, imem_req}, 32'h0);
            check("halt_flag", {31'h0, halted}, 32'h1);
            check("halt_valid", {31'h0, instr_valid}, 32'h0);
        end
        check("halt_addr", {28'h0, imem_addr}, 32'h5);
`ifdef PAPER_SEQ_BRANCH_COUNT_EN
        check("bc_final", {16'h0, branch_count}, 32'h5);
`endif
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("exit_halted", {31'h0, halted}, 32'h0);
        check("exit_addr", {28'h0, imem_addr}, 32'h0);
`ifdef PAPER_SEQ_BRANCH_COUNT_EN
        check("bc_reset", {16'h0, branch_count}, 32'h0);
`endif
        check("sb_issue_empty", exp_q.size(), 32'h0);
        check("sb_addr_empty", exp_addr_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
